// File: rtl/mux5_scan_ctrl.sv
// mux5_scan_ctrl: steps a 5-to-1 channel mux through channels 0..4, samples
// each channel at the end of its dwell, and hands the assembled 5-bit frame
// downstream over a valid/ready handshake. Single-shot or continuous scanning.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; sel parked at 0, busy low
// SCAN  | walking sel through channels 0..4, DWELL cycles each
// HOLD  | frame complete but output register still full; sel held at 4
module mux5_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic [4:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [2:0]       CH_LAST  = 3'd4;

  state_t           state;
  logic [2:0]       ch;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       shadow;
  logic             bit4;
  logic             dwell_end;
  logic             out_free;

  // ch is a register, so sel has no combinational path from any input
  assign sel       = ch;
  assign dwell_end = (cnt == CNT_LAST);
  // output register can take a new frame if empty or being drained this cycle
  assign out_free  = ~frame_valid | frame_ready;

  // scan sequencer, sample assembly and output handshake register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= 3'd0;
      cnt         <= '0;
      shadow      <= 4'd0;
      bit4        <= 1'b0;
      frame       <= 5'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // a transfer empties the output register; a load below overrides this
      if (frame_valid && frame_ready) frame_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            ch    <= 3'd0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          if (!dwell_end) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (ch < CH_LAST) begin
              shadow[ch[1:0]] <= mux_out;
              ch              <= ch + 3'd1;
            end else if (out_free) begin
              frame       <= {mux_out, shadow};
              frame_valid <= 1'b1;
              ch          <= 3'd0;
              state       <= cont ? SCAN : IDLE;
              busy        <= cont;
            end else begin
              // channel 4 must be captured now; sel stays at 4 while we wait
              bit4  <= mux_out;
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (frame_ready) begin
            frame       <= {bit4, shadow};
            frame_valid <= 1'b1;
            ch          <= 3'd0;
            cnt         <= '0;
            state       <= cont ? SCAN : IDLE;
            busy        <= cont;
          end
        end

        default: begin
          state <= IDLE;
          ch    <= 3'd0;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux5_scan_ctrl.sv
// Testbench for mux5_scan_ctrl: a DWELL=2 instance covers the main scenarios,
// a DWELL=1 instance covers the single-cycle dwell build.
module tb_mux5_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start, cont, mux_out, frame_ready, frame_valid, busy;
  logic [2:0] sel;
  logic [4:0] frame;
  logic [4:0] mux_in;

  logic       start1, cont1, mux_out1, frame_ready1, frame_valid1, busy1;
  logic [2:0] sel1;
  logic [4:0] frame1;
  logic [4:0] mux_in1;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  mux5_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_out(mux_out),
    .sel(sel), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy)
  );

  mux5_scan_ctrl #(.DWELL(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .mux_out(mux_out1),
    .sel(sel1), .frame(frame1), .frame_valid(frame_valid1),
    .frame_ready(frame_ready1), .busy(busy1)
  );

  // behavioural 5-to-1 mux
  assign mux_out  = (sel  <= 3'd4) ? mux_in[sel]   : 1'b0;
  assign mux_out1 = (sel1 <= 3'd4) ? mux_in1[sel1] : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sel !== 3'd0 || frame !== 5'd0 || frame_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut: sel=%0d frame=%b valid=%b busy=%b, want 0/00000/0/0",
               sel, frame, frame_valid, busy);
    end
    checks++;
    if (sel1 !== 3'd0 || frame1 !== 5'd0 || frame_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1: sel=%0d frame=%b valid=%b busy=%b, want 0/00000/0/0",
               sel1, frame1, frame_valid1, busy1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // single-shot frame; observation index n = edges after start acceptance
  task automatic test_single(input logic [4:0] pattern, input string name);
    logic [4:0] e;
    mux_in = pattern;
    cont = 1'b0;
    frame_ready = 1'b1;
    exp_q.push_back(pattern);
    pulse_start();
    for (int n = 0; n <= 11; n++) begin
      checks++;
      if (sel !== 3'((n < 10) ? n / 2 : 0)) begin
        errors++;
        $display("FAIL %s_sel n=%0d: got %0d want %0d", name, n, sel, (n < 10) ? n / 2 : 0);
      end
      checks++;
      if (busy !== (n < 10) || frame_valid !== (n == 10)) begin
        errors++;
        $display("FAIL %s_ctl n=%0d: busy=%b valid=%b want %b/%b", name, n, busy, frame_valid,
                 n < 10, n == 10);
      end
      if (frame_valid && frame_ready) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bxxxxx;
        if (frame !== e) begin
          errors++;
          $display("FAIL %s_frame n=%0d: got %b want %b", name, n, frame, e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    logic [4:0] e;
    mux_in = 5'b10110;
    cont = 1'b1;
    frame_ready = 1'b1;
    exp_q.push_back(5'b10110);
    exp_q.push_back(5'b00101);
    pulse_start();
    for (int n = 0; n <= 21; n++) begin
      if (n == 10) mux_in = 5'b00101;
      if (n == 12) cont = 1'b0;
      checks++;
      if (sel !== 3'((n < 20) ? (n % 10) / 2 : 0)) begin
        errors++;
        $display("FAIL cont_sel n=%0d: got %0d want %0d", n, sel, (n < 20) ? (n % 10) / 2 : 0);
      end
      checks++;
      if (busy !== (n < 20) || frame_valid !== (n == 10 || n == 20)) begin
        errors++;
        $display("FAIL cont_ctl n=%0d: busy=%b valid=%b want %b/%b", n, busy, frame_valid,
                 n < 20, n == 10 || n == 20);
      end
      if (frame_valid && frame_ready) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bxxxxx;
        if (frame !== e) begin
          errors++;
          $display("FAIL cont_frame n=%0d: got %b want %b", n, frame, e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] e;
    int exp_sel;
    mux_in = 5'b10110;
    cont = 1'b1;
    frame_ready = 1'b0;
    exp_q.push_back(5'b10110);
    exp_q.push_back(5'b11001);
    pulse_start();
    for (int n = 0; n <= 27; n++) begin
      if (n == 10) mux_in = 5'b11001;
      if (n == 20) begin
        mux_in = 5'b00000;
        cont = 1'b0;
      end
      if (n == 25) frame_ready = 1'b1;
      exp_sel = (n < 10) ? n / 2 : (n < 20) ? (n - 10) / 2 : (n < 26) ? 4 : 0;
      checks++;
      if (sel !== 3'(exp_sel)) begin
        errors++;
        $display("FAIL bp_sel n=%0d: got %0d want %0d", n, sel, exp_sel);
      end
      checks++;
      if (busy !== (n <= 25) || frame_valid !== (n >= 10 && n <= 26)) begin
        errors++;
        $display("FAIL bp_ctl n=%0d: busy=%b valid=%b want %b/%b", n, busy, frame_valid,
                 n <= 25, n >= 10 && n <= 26);
      end
      if (frame_valid) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q[0] : 5'bxxxxx;
        if (frame !== e) begin
          errors++;
          $display("FAIL bp_frame n=%0d: got %b want %b", n, frame, e);
        end
        if (frame_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_scan();
    mux_in = 5'b10110;
    cont = 1'b1;
    frame_ready = 1'b0;
    pulse_start();
    repeat (14) @(negedge clk);
    checks++;
    if (sel !== 3'd2 || frame_valid !== 1'b1 || frame !== 5'b10110) begin
      errors++;
      $display("FAIL rstmid_pre: sel=%0d valid=%b frame=%b want 2/1/10110", sel, frame_valid, frame);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sel !== 3'd0 || frame_valid !== 1'b0 || frame !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: sel=%0d valid=%b frame=%b busy=%b want 0/0/00000/0",
               sel, frame_valid, frame, busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cont = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    test_single(5'b01101, "rstmid_after");
  endtask

  task automatic test_dwell1();
    logic [4:0] e;
    mux_in1 = 5'b01011;
    cont1 = 1'b0;
    frame_ready1 = 1'b1;
    exp_q.push_back(5'b01011);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      if (n == 1) start1 = 1'b1;
      if (n == 4) start1 = 1'b0;
      checks++;
      if (sel1 !== 3'((n < 5) ? n : 0)) begin
        errors++;
        $display("FAIL d1_sel n=%0d: got %0d want %0d", n, sel1, (n < 5) ? n : 0);
      end
      checks++;
      if (busy1 !== (n < 5) || frame_valid1 !== (n == 5)) begin
        errors++;
        $display("FAIL d1_ctl n=%0d: busy=%b valid=%b want %b/%b", n, busy1, frame_valid1,
                 n < 5, n == 5);
      end
      if (frame_valid1 && frame_ready1) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bxxxxx;
        if (frame1 !== e) begin
          errors++;
          $display("FAIL d1_frame n=%0d: got %b want %b", n, frame1, e);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;  cont = 1'b0;  frame_ready = 1'b1;  mux_in = 5'd0;
    start1 = 1'b0; cont1 = 1'b0; frame_ready1 = 1'b1; mux_in1 = 5'd0;

    test_reset();
    test_single(5'b10110, "idle_single");
    test_single(5'b10000, "ch4_only");
    test_single(5'b01111, "ch4_isolate");
    test_continuous();
    test_backpressure();
    test_reset_mid_scan();
    test_dwell1();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames never delivered, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
